// File: rtl/cpu_pkg.sv
// Shared MIPS pipeline constants: opcodes, control-word bit positions and
// the register-usage rules used by hazard detection.
package cpu_pkg;

    localparam int CTRL_W = 9;

    // Control word layout: {reg_write,mem_to_reg,mem_read,mem_write,branch,alu_src,reg_dst,alu_op[1:0]}
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_TO_REG = 7;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_REG_DST    = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Deliberately conservative: only opcodes that never read rs are excluded.
    function automatic logic uses_rs(input logic [5:0] op);
        return !(op == OP_J || op == OP_JAL || op == OP_LUI);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// (rt) is read by the instruction in ID forces a one-cycle freeze.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    output logic       stall
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = uses_rs(id_opcode) && (ex_rt == id_rs);
    assign rt_hit = uses_rt(id_opcode) && (ex_rt == id_rt);

    // $zero is never a real dependency; a flushed ID instruction needs no wait.
    assign stall = ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
                   id_valid && !flush && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating bubble counter.
module id_ex_pipe_reg
    import cpu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [DW-1:0]     id_rs_data,
    input  logic [DW-1:0]     id_rt_data,
    input  logic [DW-1:0]     id_ext_immed,
    input  logic [DW-1:0]     id_pc_plus4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [DW-1:0]     ex_rs_data,
    output logic [DW-1:0]     ex_rt_data,
    output logic [DW-1:0]     ex_ext_immed,
    output logic [DW-1:0]     ex_pc_plus4,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [DW-1:0]     rs_data;
        logic [DW-1:0]     rt_data;
        logic [DW-1:0]     ext_immed;
        logic [DW-1:0]     pc_plus4;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t id_in;

    // valid marks a real instruction; an invalid slot always carries zero control
    // so no downstream stage can act on stale control bits.
    always_comb begin
        id_in           = '0;
        id_in.valid     = id_valid;
        id_in.opcode    = id_opcode;
        id_in.funct     = id_funct;
        id_in.rs        = id_rs;
        id_in.rt        = id_rt;
        id_in.rd        = id_rd;
        id_in.shamt     = id_shamt;
        id_in.rs_data   = id_rs_data;
        id_in.rt_data   = id_rt_data;
        id_in.ext_immed = id_ext_immed;
        id_in.pc_plus4  = id_pc_plus4;
        id_in.ctrl      = id_valid ? id_ctrl : '0;
    end

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.ctrl[CTRL_MEM_READ]),
        .ex_rt       (ex_q.rt),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .flush       (flush),
        .stall       (load_use_stall)
    );

    // Priority: reset > flush > hold > bubble > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (hold) begin
            ex_q <= ex_q;
        end else if (load_use_stall) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_in;
        end
    end

    // A stall under hold inserts no bubble, so it is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (load_use_stall && !hold && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct     = ex_q.funct;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_rd        = ex_q.rd;
    assign ex_shamt     = ex_q.shamt;
    assign ex_rs_data   = ex_q.rs_data;
    assign ex_rt_data   = ex_q.rt_data;
    assign ex_ext_immed = ex_q.ext_immed;
    assign ex_pc_plus4  = ex_q.pc_plus4;
    assign ex_ctrl      = ex_q.ctrl;

endmodule
